// File: rtl/ft_pkg.sv
// ft_pkg: shared width, capture FSM states and zero-instruction constant for the fetch-target buffer.
package ft_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] FT_NOP = 32'h0000_0000;
  typedef enum logic {FT_BTB_IDLE, FT_BTB_ARMED} ft_btb_state_e;
endpackage

// File: rtl/ft_btb_cam.sv
// ft_btb_cam: combinational ENTRIES-way tag compare with hit and lowest-free-slot encoding.
module ft_btb_cam #(
  parameter int ENTRIES = 4,
  parameter int XLEN    = 32,
  parameter int IW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic [ENTRIES-1:0]           valid_i,
  input  logic [ENTRIES-1:0][XLEN-1:0] tag_i,
  input  logic [XLEN-1:0]              key_i,
  output logic [ENTRIES-1:0]           match_o,
  output logic [IW-1:0]                hit_idx_o,
  output logic                         hit_o,
  output logic [IW-1:0]                free_idx_o,
  output logic                         free_o
);
  for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
    assign match_o[g] = valid_i[g] && tag_i[g] == key_i;
  end
  assign hit_o = |match_o;
  // Scanning downwards leaves the lowest-index invalid slot as the winner.
  always_comb begin
    hit_idx_o  = '0;
    free_idx_o = '0;
    free_o     = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match_o[i]) hit_idx_o = IW'(i);
      if (!valid_i[i]) begin
        free_idx_o = IW'(i);
        free_o     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ft_btb.sv
// ft_btb: fully-associative buffer of instructions captured at branch targets, looked up by fetch PC.
module ft_btb #(
  parameter int ENTRIES = 4,
  parameter int XLEN    = ft_pkg::XLEN,
  parameter int WARMUP  = 10
) (
  input  logic            clk,
  input  logic            cpurst_n,
  input  logic            de2fe_branch,
  input  logic            de2ex_inst_valid,
  input  logic [XLEN-1:0] fe2de_pc_ffout,
  input  logic [XLEN-1:0] fe2de_instr_ffout,
  input  logic            fe2de_rv16_ffout,
  input  logic [15:0]     fe2de_rv16_instr_ffout,
  input  logic            btb_inval,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            btb_hit,
  output logic [XLEN-1:0] btb_instr,
  output logic            btb_rv16,
  output logic            btb_valid
);
  import ft_pkg::*;
  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  ft_btb_state_e               state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [IW-1:0]               rr_q, rr_d;
  logic [ENTRIES-1:0]          valid_q, valid_d;
  logic [ENTRIES-1:0][XLEN-1:0] tag_q, data_q;
  logic [ENTRIES-1:0]          rv16_q;
  logic [ENTRIES-1:0]          l_match, w_match;
  logic [IW-1:0]               l_idx, l_free_idx, w_idx, w_free_idx, slot;
  logic                        l_hit, l_free, w_hit, w_free, wr;
  logic [XLEN-1:0]             wdata;
  ft_btb_cam #(.ENTRIES(ENTRIES), .XLEN(XLEN), .IW(IW)) u_lookup_cam (
    .valid_i(valid_q), .tag_i(tag_q), .key_i(lookup_pc),
    .match_o(l_match), .hit_idx_o(l_idx), .hit_o(l_hit),
    .free_idx_o(l_free_idx), .free_o(l_free)
  );
  ft_btb_cam #(.ENTRIES(ENTRIES), .XLEN(XLEN), .IW(IW)) u_write_cam (
    .valid_i(valid_q), .tag_i(tag_q), .key_i(fe2de_pc_ffout),
    .match_o(w_match), .hit_idx_o(w_idx), .hit_o(w_hit),
    .free_idx_o(w_free_idx), .free_o(w_free)
  );
  logic unused_cam;
  assign unused_cam = ^{l_match, w_match, l_free_idx, l_free};
  assign btb_valid = cnt_q == CW'(WARMUP);
  assign btb_hit   = btb_valid && l_hit;
  assign btb_instr = btb_hit ? data_q[l_idx] : XLEN'(FT_NOP);
  assign btb_rv16  = btb_hit && rv16_q[l_idx];
  assign wr    = state_q == FT_BTB_ARMED && de2ex_inst_valid && !btb_inval;
  assign wdata = fe2de_rv16_ffout ? XLEN'(fe2de_rv16_instr_ffout) : fe2de_instr_ffout;
  assign slot  = w_hit ? w_idx : w_free ? w_free_idx : rr_q;
  always_comb begin
    state_d = state_q;
    if (btb_inval) state_d = FT_BTB_IDLE;
    else if (state_q == FT_BTB_IDLE || de2ex_inst_valid)
      state_d = de2fe_branch ? FT_BTB_ARMED : FT_BTB_IDLE;
  end
  // Round-robin pointer advances only when a full buffer forces an eviction.
  always_comb begin
    cnt_d   = cnt_q == CW'(WARMUP) ? cnt_q : cnt_q + 1'b1;
    valid_d = valid_q;
    rr_d    = rr_q;
    if (wr) valid_d[slot] = 1'b1;
    if (wr && !w_hit && !w_free) rr_d = rr_q == IW'(ENTRIES - 1) ? '0 : rr_q + 1'b1;
    if (btb_inval) begin
      valid_d = '0;
      rr_d    = '0;
    end
  end
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state_q <= FT_BTB_IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      valid_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      rv16_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      if (wr) begin
        tag_q[slot]  <= fe2de_pc_ffout;
        data_q[slot] <= wdata;
        rv16_q[slot] <= fe2de_rv16_ffout;
      end
    end
  end
endmodule

// File: tb/tb_ft_btb.sv
// tb_ft_btb: directed checks of warm-up, capture, allocation, invalidation and re-arm.
module tb_ft_btb;
  logic        clk = 1'b0;
  logic        cpurst_n = 1'b0;
  logic        de2fe_branch = 1'b0, de2ex_inst_valid = 1'b0;
  logic [31:0] fe2de_pc_ffout = '0, fe2de_instr_ffout = '0;
  logic        fe2de_rv16_ffout = 1'b0;
  logic [15:0] fe2de_rv16_instr_ffout = '0;
  logic        btb_inval = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        btb_hit, btb_rv16, btb_valid;
  logic [31:0] btb_instr;
  int n_assert = 0, n_fail = 0;

  ft_btb #(.ENTRIES(4), .XLEN(32), .WARMUP(10)) dut (
    .clk(clk), .cpurst_n(cpurst_n),
    .de2fe_branch(de2fe_branch), .de2ex_inst_valid(de2ex_inst_valid),
    .fe2de_pc_ffout(fe2de_pc_ffout), .fe2de_instr_ffout(fe2de_instr_ffout),
    .fe2de_rv16_ffout(fe2de_rv16_ffout), .fe2de_rv16_instr_ffout(fe2de_rv16_instr_ffout),
    .btb_inval(btb_inval), .lookup_pc(lookup_pc),
    .btb_hit(btb_hit), .btb_instr(btb_instr), .btb_rv16(btb_rv16), .btb_valid(btb_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic [31:0] instr, input logic rv16);
    lookup_pc = pc;
    #1;
    check({tag, ".hit"}, 32'(btb_hit), 32'(hit));
    check({tag, ".instr"}, btb_instr, instr);
    check({tag, ".rv16"}, 32'(btb_rv16), 32'(rv16));
  endtask

  task automatic cap(input logic [31:0] pc, input logic [31:0] instr,
                     input logic rv16, input logic [15:0] i16);
    de2fe_branch = 1'b1;
    step();
    de2fe_branch = 1'b0;
    de2ex_inst_valid = 1'b1;
    fe2de_pc_ffout = pc;
    fe2de_instr_ffout = instr;
    fe2de_rv16_ffout = rv16;
    fe2de_rv16_instr_ffout = i16;
    step();
    de2ex_inst_valid = 1'b0;
    fe2de_rv16_ffout = 1'b0;
  endtask

  task automatic inval();
    btb_inval = 1'b1;
    step();
    btb_inval = 1'b0;
  endtask

  initial begin
    step();
    check("rst.valid", 32'(btb_valid), 32'd0);
    look("rst.look0", 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    cpurst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("warm.c%0d", k), 32'(btb_valid), (k >= 10) ? 32'd1 : 32'd0);
      if (k == 5 || k == 11) look($sformatf("warm.look%0d", k), 32'h0, 1'b0, 32'h0, 1'b0);
    end
    cap(32'h100, 32'h0050_0093, 1'b0, 16'h0);
    look("basic", 32'h100, 1'b1, 32'h0050_0093, 1'b0);
    look("basic.miss", 32'h104, 1'b0, 32'h0, 1'b0);
    cap(32'h200, 32'hDEAD_BEEF, 1'b1, 16'h4505);
    look("rv16", 32'h200, 1'b1, 32'h0000_4505, 1'b1);
    inval();
    look("inval.100", 32'h100, 1'b0, 32'h0, 1'b0);
    look("inval.200", 32'h200, 1'b0, 32'h0, 1'b0);
    cap(32'h10, 32'h11, 1'b0, 16'h0);
    cap(32'h20, 32'h22, 1'b0, 16'h0);
    cap(32'h30, 32'h33, 1'b0, 16'h0);
    cap(32'h40, 32'h44, 1'b0, 16'h0);
    look("fill.10", 32'h10, 1'b1, 32'h11, 1'b0);
    look("fill.40", 32'h40, 1'b1, 32'h44, 1'b0);
    cap(32'h50, 32'h55, 1'b0, 16'h0);
    look("evict.10", 32'h10, 1'b0, 32'h0, 1'b0);
    look("evict.50", 32'h50, 1'b1, 32'h55, 1'b0);
    look("evict.20kept", 32'h20, 1'b1, 32'h22, 1'b0);
    cap(32'h60, 32'h66, 1'b0, 16'h0);
    look("evict.20", 32'h20, 1'b0, 32'h0, 1'b0);
    look("evict.60", 32'h60, 1'b1, 32'h66, 1'b0);
    cap(32'h30, 32'h3333, 1'b0, 16'h0);
    look("upd.30", 32'h30, 1'b1, 32'h3333, 1'b0);
    look("upd.50", 32'h50, 1'b1, 32'h55, 1'b0);
    look("upd.60", 32'h60, 1'b1, 32'h66, 1'b0);
    look("upd.40", 32'h40, 1'b1, 32'h44, 1'b0);
    // rr still points at slot 2 (holding 0x30), since the update did not advance it
    cap(32'h70, 32'h77, 1'b0, 16'h0);
    look("rr.70", 32'h70, 1'b1, 32'h77, 1'b0);
    look("rr.30", 32'h30, 1'b0, 32'h0, 1'b0);
    look("rr.40", 32'h40, 1'b1, 32'h44, 1'b0);
    de2fe_branch = 1'b1;
    step();
    de2fe_branch = 1'b0;
    de2ex_inst_valid = 1'b1;
    fe2de_pc_ffout = 32'h80;
    fe2de_instr_ffout = 32'h88;
    btb_inval = 1'b1;
    step();
    btb_inval = 1'b0;
    look("coll.80", 32'h80, 1'b0, 32'h0, 1'b0);
    look("coll.70", 32'h70, 1'b0, 32'h0, 1'b0);
    look("coll.40", 32'h40, 1'b0, 32'h0, 1'b0);
    fe2de_pc_ffout = 32'h99;
    step();
    de2ex_inst_valid = 1'b0;
    look("coll.idle", 32'h99, 1'b0, 32'h0, 1'b0);
    cap(32'h11, 32'h1, 1'b0, 16'h0);
    cap(32'h12, 32'h2, 1'b0, 16'h0);
    cap(32'h13, 32'h3, 1'b0, 16'h0);
    cap(32'h14, 32'h4, 1'b0, 16'h0);
    cap(32'h15, 32'h5, 1'b0, 16'h0);
    look("rr0.11", 32'h11, 1'b0, 32'h0, 1'b0);
    look("rr0.14", 32'h14, 1'b1, 32'h4, 1'b0);
    look("rr0.15", 32'h15, 1'b1, 32'h5, 1'b0);
    inval();
    de2fe_branch = 1'b1;
    step();
    de2ex_inst_valid = 1'b1;
    fe2de_pc_ffout = 32'h90;
    fe2de_instr_ffout = 32'h909;
    step();
    de2fe_branch = 1'b0;
    fe2de_pc_ffout = 32'hA0;
    fe2de_instr_ffout = 32'hA0A;
    step();
    de2ex_inst_valid = 1'b0;
    look("rearm.90", 32'h90, 1'b1, 32'h909, 1'b0);
    look("rearm.A0", 32'hA0, 1'b1, 32'hA0A, 1'b0);
    de2fe_branch = 1'b1;
    de2ex_inst_valid = 1'b1;
    fe2de_pc_ffout = 32'hB0;
    fe2de_instr_ffout = 32'hB0B;
    step();
    de2fe_branch = 1'b0;
    de2ex_inst_valid = 1'b0;
    look("armonly.B0", 32'hB0, 1'b0, 32'h0, 1'b0);
    de2ex_inst_valid = 1'b1;
    fe2de_pc_ffout = 32'hC0;
    fe2de_instr_ffout = 32'hC0C;
    step();
    de2ex_inst_valid = 1'b0;
    look("armonly.C0", 32'hC0, 1'b1, 32'hC0C, 1'b0);
    de2fe_branch = 1'b1;
    step();
    de2fe_branch = 1'b0;
    cpurst_n = 1'b0;
    #2;
    check("arst.valid", 32'(btb_valid), 32'd0);
    cpurst_n = 1'b1;
    de2ex_inst_valid = 1'b1;
    fe2de_pc_ffout = 32'hD0;
    fe2de_instr_ffout = 32'hD0D;
    step();
    de2ex_inst_valid = 1'b0;
    repeat (10) step();
    check("arst.warm", 32'(btb_valid), 32'd1);
    look("arst.D0", 32'hD0, 1'b0, 32'h0, 1'b0);
    look("arst.C0", 32'hC0, 1'b0, 32'h0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
